// File: rtl/entropy_collector.sv
// Purpose : pulls 32-bit words from an avalanche entropy source, runs a repetition-count
//           health test on each word and buffers passing words in a small FWFT FIFO.
// Latency : 2 cycles from source sample to out_valid; peak one word every 2 cycles.
// Backpressure: no source sample while the FIFO is full; a stuck source raises a sticky
//           rep_error, flushes the FIFO and halts collection until clear_error.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   enable, src_enabled     collection enable / source reports itself enabled
//   src_data, src_valid     source word and its valid flag
//   src_ack                 registered one-cycle acknowledge back to the source
//   out_data, out_valid     FIFO head word (0 when empty) and FIFO-not-empty
//   out_ack                 consumer pops the head
//   clear_error             clears rep_error and the health-test history
//   rep_error               sticky repetition-test failure
//   fill_level              FIFO occupancy
//   word_ctr                number of words written to the FIFO (wraps)
module entropy_collector #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned REP_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     src_enabled,
    input  logic [31:0]              src_data,
    input  logic                     src_valid,
    output logic                     src_ack,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ack,
    input  logic                     clear_error,
    output logic                     rep_error,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [31:0]              word_ctr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(REP_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIMIT_L = CW'(REP_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SRC = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cap_q, cap_d;
    logic [31:0]   last_q, last_d;
    logic          last_vld_q, last_vld_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic [CW-1:0] rep_cnt_nxt;
    logic          rep_error_q, rep_error_d;
    logic          src_ack_q, src_ack_d;
    logic [31:0]   word_ctr_q, word_ctr_d;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, flush;

    // Run length the captured word would have if accepted.
    assign rep_cnt_nxt = (last_vld_q && (cap_q == last_q)) ? rep_cnt_q + CW'(1) : CW'(1);

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        rep_cnt_d   = rep_cnt_q;
        rep_error_d = rep_error_q;
        src_ack_d   = 1'b0;
        word_ctr_d  = word_ctr_q;
        push        = 1'b0;
        flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && src_enabled && !rep_error_q) begin
                    state_d = WAIT_SRC;
                end
            end
            WAIT_SRC: begin
                if (!enable || !src_enabled) begin
                    state_d = IDLE;
                end else if (src_valid && (count_q < DEPTH_L)) begin
                    // Only one capture is ever in flight, so this full check is exact.
                    cap_d     = src_data;
                    src_ack_d = 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                rep_cnt_d = rep_cnt_nxt;
                if (rep_cnt_nxt == LIMIT_L) begin
                    rep_error_d = 1'b1;
                    flush       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    push       = 1'b1;
                    word_ctr_d = word_ctr_q + 32'd1;
                    last_d     = cap_q;
                    last_vld_d = 1'b1;
                    state_d    = enable ? WAIT_SRC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A failure detected this cycle takes precedence over a software clear.
        if (clear_error && !flush) begin
            rep_error_d = 1'b0;
            rep_cnt_d   = '0;
            last_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            last_q      <= '0;
            last_vld_q  <= 1'b0;
            rep_cnt_q   <= '0;
            rep_error_q <= 1'b0;
            src_ack_q   <= 1'b0;
            word_ctr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_error_q <= rep_error_d;
            src_ack_q   <= src_ack_d;
            word_ctr_q  <= word_ctr_d;
        end
    end

    // FIFO: pointers and occupancy; a flush discards everything including a same-cycle pop.
    assign pop = (count_q != '0) && out_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: occupancy gates everything that is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign fill_level = count_q;
    assign src_ack    = src_ack_q;
    assign rep_error  = rep_error_q;
    assign word_ctr   = word_ctr_q;

endmodule

// File: tb/tb_entropy_collector.sv
// Purpose : self-checking bench for entropy_collector against a queue-based reference model.
// Latency : model commits an acknowledged word one cycle after src_ack is observed.
// Backpressure: consumer ack and source valid driven from per-cycle random percentages.
module tb_entropy_collector;

    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        src_enabled = 1'b0;
    logic [31:0] src_data = 32'h0;
    logic        src_valid = 1'b0;
    logic        src_ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic        clear_error = 1'b0;
    logic        rep_error;
    logic [$clog2(DEPTH):0] fill_level;
    logic [31:0] word_ctr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    entropy_collector #(.DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .src_enabled (src_enabled),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ack     (src_ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ack     (out_ack),
        .clear_error (clear_error),
        .rep_error   (rep_error),
        .fill_level  (fill_level),
        .word_ctr    (word_ctr)
    );

    // Reference model: FIFO contents, delivered-word count, error flag and run-length history.
    logic [31:0] m_q [$];
    logic [31:0] m_ctr;
    bit          m_err;
    logic [31:0] m_last;
    bit          m_have;
    int          m_run;
    bit          pend_vld;
    bit          pend_clr;
    logic [31:0] pend_word;

    // Stimulus knobs.
    int          mode;          // 0 constant, 1 incrementing, 2 random with repeats
    int unsigned valid_pct, ack_pct, en_pct, clr_pct;
    bit          rand_ctl, pulse_ack, clr_pulse, drop_en_on_ack;
    int          ack_cnt, pop_cnt;
    bit          ack_prev, sv_prev;
    int          size_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ctr     = 32'h0;
        m_err     = 1'b0;
        m_last    = 32'h0;
        m_have    = 1'b0;
        m_run     = 0;
        pend_vld  = 1'b0;
        pend_clr  = 1'b0;
        ack_prev  = 1'b0;
        size_prev = 0;
    endtask

    task automatic model_word(input logic [31:0] w, output bit tripped);
        tripped = 1'b0;
        if (m_have && w == m_last) m_run++;
        else m_run = 1;
        if (m_run == REP_LIMIT) begin
            m_err = 1'b1;
            m_q.delete();
            tripped = 1'b1;
        end else begin
            m_q.push_back(w);
            m_ctr  = m_ctr + 32'd1;
            m_last = w;
            m_have = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_src_ack"},   32'(src_ack),    32'h0);
        check({tag, "_out_valid"}, 32'(out_valid),  32'h0);
        check({tag, "_out_data"},  out_data,        32'h0);
        check({tag, "_rep_error"}, 32'(rep_error),  32'h0);
        check({tag, "_fill"},      32'(fill_level), 32'h0);
        check({tag, "_word_ctr"},  word_ctr,        32'h0);
    endtask

    // One clock: commit last cycle's capture, compare, react to src_ack, drive next inputs.
    task automatic cycle();
        bit          tripped;
        logic [31:0] exp_d;
        @(negedge clk);
        tripped = 1'b0;
        if (pend_vld) begin
            model_word(pend_word, tripped);
            pend_vld = 1'b0;
        end
        if (pend_clr) begin
            if (!tripped) begin
                m_err  = 1'b0;
                m_run  = 0;
                m_have = 1'b0;
            end
            pend_clr = 1'b0;
        end

        exp_d = (m_q.size() != 0) ? m_q[0] : 32'h0;
        check("fill_level", 32'(fill_level), 32'(m_q.size()));
        check("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
        check("out_data",   out_data,        exp_d);
        check("rep_error",  32'(rep_error),  32'(m_err));
        check("word_ctr",   word_ctr,        m_ctr);

        if (src_ack) begin
            check("ack_without_valid", 32'(sv_prev),            32'h1);
            check("ack_when_full",     32'(size_prev < DEPTH),  32'h1);
            check("ack_back_to_back",  32'(ack_prev),           32'h0);
            check("ack_in_error",      32'(rep_error),          32'h0);
            pend_vld  = 1'b1;
            pend_word = src_data;
            ack_cnt++;
            if (drop_en_on_ack) enable = 1'b0;
            case (mode)
                1: src_data = src_data + 32'd1;
                2: if ($urandom_range(0, 99) >= 85) src_data = $urandom;
                default: ;
            endcase
        end
        ack_prev  = src_ack;
        size_prev = m_q.size();

        out_ack   = pulse_ack || ($urandom_range(0, 99) < ack_pct);
        pulse_ack = 1'b0;
        if (out_ack && m_q.size() != 0) begin
            void'(m_q.pop_front());
            pop_cnt++;
        end

        clear_error = clr_pulse || ($urandom_range(0, 99) < clr_pct);
        clr_pulse   = 1'b0;
        pend_clr    = clear_error;

        if (rand_ctl) begin
            enable      = ($urandom_range(0, 99) < en_pct);
            src_enabled = ($urandom_range(0, 99) < en_pct);
        end
        src_valid = ($urandom_range(0, 99) < valid_pct);
        sv_prev   = src_valid;
    endtask

    initial begin
        bit found;
        mode = 0; valid_pct = 0; ack_pct = 0; en_pct = 100; clr_pct = 0;
        rand_ctl = 0; pulse_ack = 0; clr_pulse = 0; drop_en_on_ack = 0;
        ack_cnt = 0; pop_cnt = 0; sv_prev = 0;
        model_reset();

        // Reset values, asynchronously.
        #1 reset_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) cycle();
        reset_n = 1'b1;

        // Stuck source: 7 words delivered, the 8th trips the health test.
        mode = 0; src_data = 32'h1122_3344;
        enable = 1'b1; src_enabled = 1'b1; valid_pct = 100; ack_pct = 100;
        ack_cnt = 0; pop_cnt = 0;
        repeat (40) cycle();
        check("const_acks",     32'(ack_cnt),   32'd8);
        check("const_pops",     32'(pop_cnt),   32'd7);
        check("const_word_ctr", word_ctr,       32'd7);
        check("const_error",    32'(rep_error), 32'd1);
        check("const_valid",    32'(out_valid), 32'd0);
        ack_cnt = 0;
        repeat (20) cycle();
        check("const_no_ack_in_error", 32'(ack_cnt), 32'd0);

        // Clear with an incrementing source: collection resumes, word_ctr continues.
        mode = 1; src_data = 32'h0; clr_pulse = 1'b1; ack_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = (ack_cnt == 1);
        end
        check("clear_resume_ack", 32'(found), 32'd1);
        cycle();
        check("clear_word_ctr", word_ctr, 32'd8);

        // Steady-state throughput: one word every 2 cycles.
        repeat (10) cycle();
        ack_cnt = 0;
        repeat (200) cycle();
        check("incr_acks_200", 32'(ack_cnt),   32'd100);
        check("incr_no_error", 32'(rep_error), 32'd0);

        // Full FIFO stalls the source; one pop admits exactly one word.
        ack_pct = 0;
        repeat (20) cycle();
        check("full_level", 32'(fill_level), 32'(DEPTH));
        ack_cnt = 0;
        repeat (10) cycle();
        check("full_no_ack", 32'(ack_cnt), 32'd0);
        pulse_ack = 1'b1;
        repeat (10) cycle();
        check("full_one_ack",   32'(ack_cnt),    32'd1);
        check("full_refilled",  32'(fill_level), 32'(DEPTH));

        // Drain with enable low, then drop enable in the src_ack cycle.
        enable = 1'b0; ack_pct = 100;
        repeat (10) cycle();
        check("drain_empty", 32'(fill_level), 32'd0);
        ack_pct = 0; enable = 1'b1; drop_en_on_ack = 1'b1; ack_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = (ack_cnt == 1);
        end
        check("drop_en_ack_seen", 32'(found), 32'd1);
        drop_en_on_ack = 1'b0;
        repeat (6) cycle();
        check("drop_en_written", 32'(fill_level), 32'd1);
        check("drop_en_stopped", 32'(ack_cnt),    32'd1);
        ack_pct = 100;
        repeat (4) cycle();
        check("drop_en_drained", 32'(fill_level), 32'd0);

        // Random traffic with repeats, enable toggles and occasional clears.
        mode = 2; rand_ctl = 1; valid_pct = 70; ack_pct = 50; en_pct = 95; clr_pct = 3;
        repeat (3000) cycle();
        rand_ctl = 0; clr_pct = 0;

        // Reset in the middle of a capture with three words buffered.
        mode = 1; clr_pulse = 1'b1; enable = 1'b0; src_enabled = 1'b1; ack_pct = 100;
        repeat (10) cycle();
        ack_pct = 0; valid_pct = 100; enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            found = (fill_level == 3) && src_ack;
        end
        check("rst_setup_found", 32'(found), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("rst_async");
        model_reset();
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        check("rst_no_early_ack", 32'(src_ack), 32'd0);
        ack_pct = 50; ack_cnt = 0;
        repeat (30) cycle();
        check("rst_resumes", 32'(ack_cnt > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/entropy_collector.md
# entropy_collector

Downstream consumer of an avalanche entropy source. It pulls 32-bit entropy words over the source's `entropy_valid`/`entropy_ack` handshake and runs a repetition-count health test on each word. Passing words are buffered in a small first-word-fall-through FIFO that feeds the mixer over a valid/ack interface. A detected stuck source raises a sticky security error, flushes the buffer and stops collection until software clears it.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `REP_LIMIT`, 8: number of consecutive identical words that trips the health test; at least 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  collection enable.
- `src_enabled`  in  1  source's `entropy_enabled`.
- `src_data`  in  32  source's `entropy_data`.
- `src_valid`  in  1  source's `entropy_valid`.
- `src_ack`  out  1  to source's `entropy_ack`; registered one-cycle pulse.
- `out_data`  out  32  FIFO head word; 0 when the FIFO is empty.
- `out_valid`  out  1  FIFO not empty.
- `out_ack`  in  1  consumer pops the head.
- `clear_error`  in  1  clears `rep_error` and the health-test state.
- `rep_error`  out  1  sticky repetition-test failure.
- `fill_level`  out  log2(DEPTH)+1  FIFO occupancy.
- `word_ctr`  out  32  count of words written to the FIFO.

## Operation
- FSM states: IDLE, WAIT_SRC, CAPTURE. Reset state is IDLE.
- IDLE: `src_ack`=0. Go to WAIT_SRC when `enable` && `src_enabled` && !`rep_error`.
- WAIT_SRC:
  - If `enable`=0 or `src_enabled`=0, go to IDLE.
  - Else if `src_valid`=1 and `fill_level`<DEPTH: register `src_data` into the capture register, set `src_ack`=1 for the next cycle, go to CAPTURE.
- CAPTURE (one cycle): compare the capture register with the last accepted word.
  - First word after reset or clear (last-valid flag = 0): `rep_cnt`=1.
  - Equal to the last word: `rep_cnt`+1. Different: `rep_cnt`=1.
  - If the new `rep_cnt` equals REP_LIMIT:
    - discard the word;
    - set `rep_error`;
    - flush the FIFO (`fill_level`=0);
    - go to IDLE.
  - Otherwise:
    - write the word to the FIFO and increment `word_ctr` (wraps at 2^32);
    - update the last word and set the last-valid flag;
    - go to WAIT_SRC, or to IDLE if `enable`=0.
- Only one capture is ever in flight. The full check in WAIT_SRC is therefore exact: pops can only lower the level.
- FIFO pop happens when `out_valid` && `out_ack`. `out_ack` while empty is ignored.
- Push and pop in the same cycle leave `fill_level` unchanged. A pop in a flush cycle is superseded by the flush.
- While `rep_error`=1: no collection, FIFO held empty, `out_valid`=0.
- `clear_error`: clears `rep_error`, `rep_cnt` and the last-valid flag.
  - If an error sets in the same cycle, the set wins.
  - `word_ctr` is not cleared.
- `enable` dropping leaves FIFO contents intact and drainable. An in-progress CAPTURE completes.
- Reset values: state IDLE, `src_ack` 0, `out_valid` 0, `out_data` 0, `rep_error` 0, `fill_level` 0, `word_ctr` 0, `rep_cnt` 0, last-valid flag 0.
- Reset asserted mid-operation aborts any capture immediately and discards FIFO contents.

## Timing
- Cycle N: WAIT_SRC samples `src_valid`=1 with space available. Data is captured at the end of N.
- Cycle N+1: `src_ack`=1 and state is CAPTURE. The FIFO write happens at the end of N+1.
- Cycle N+2: `out_valid`=1 if the FIFO was empty. `src_ack` is back to 0. State is WAIT_SRC, and the next word can be sampled in N+2.
- Peak throughput is one word per 2 cycles. Latency from source sample to `out_valid` is 2 cycles.
- `rep_error` rises in cycle N+2 for a failing word, with `fill_level`=0 in the same cycle.
- `out_data` and `out_valid` change only on clock edges (registered head, FWFT).

## Test plan
- Constant source 0x11223344, `src_valid`=1, `enable`=1, `out_ack`=1 → 7 words delivered, all 0x11223344. The 8th word trips the test: `rep_error`=1, `out_valid`=0, `word_ctr`=7, no further `src_ack`.
- Incrementing source 0x0,0x1,… with `out_ack`=1 → `src_ack` pulses every 2nd cycle; `out_data` sequence 0,1,2,… in order; `rep_error` stays 0 for 100 words.
- Incrementing source with `out_ack`=0 → `fill_level` reaches 4 and `src_ack` stays 0. One `out_ack` pulse → exactly one new `src_ack` and `fill_level` returns to 4.
- After the error in the first scenario, pulse `clear_error` with the source switched to incrementing → collection resumes, the first word is accepted with `rep_cnt`=1, and `word_ctr` continues from 7.
- Drop `enable` in the cycle `src_ack`=1 → that word is still written, then state IDLE. Existing words drain via `out_ack`.
- Assert `reset_n`=0 with `fill_level`=3 mid-capture → all outputs take reset values asynchronously. After release, no `src_ack` occurs until WAIT_SRC is reached.
